// File: rtl/uart_prog_loader_if.sv
// Instruction-memory write port and core-control
// outputs of the UART program loader.
interface uart_prog_loader_if #(
  parameter int ADDR_W = 8
);
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  modport master (
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output cpu_hold,
    output done,
    output error
  );

  modport slave (
    input mem_we,
    input mem_addr,
    input mem_wdata,
    input cpu_hold,
    input done,
    input error
  );
endinterface

// File: rtl/uart_prog_loader.sv
// UART boot loader: 8N1 receiver plus framed-image
// loader writing little-endian words to instr memory.
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 217,
  parameter int ADDR_W       = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                i_rxd,
  uart_prog_loader_if.master  o_mem
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 =
    CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] FULL_M1 =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [7:0] SYNC = 8'hA5;

  typedef enum logic [1:0] {
    R_IDLE, R_START, R_DATA, R_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    L_IDLE, L_COUNT, L_DATA,
    L_CHECK, L_DONE, L_ERR
  } ld_state_t;

  logic r_rxd_s1;
  logic r_rxd_s2;

  rx_state_t r_rx_state;
  rx_state_t w_rx_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic [2:0] r_bit;
  logic [2:0] w_bit_next;
  logic [7:0] r_shift;
  logic [7:0] w_shift_next;
  logic r_byte_valid;
  logic w_bv_next;
  logic r_frame_err;
  logic w_fe_next;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rxd_s1 <= 1'b1;
      r_rxd_s2 <= 1'b1;
    end else begin
      r_rxd_s1 <= i_rxd;
      r_rxd_s2 <= r_rxd_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rx_state   <= R_IDLE;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_rx_state   <= w_rx_next;
      r_cnt        <= w_cnt_next;
      r_bit        <= w_bit_next;
      r_shift      <= w_shift_next;
      r_byte_valid <= w_bv_next;
      r_frame_err  <= w_fe_next;
    end
  end

  always_comb begin
    w_rx_next    = r_rx_state;
    w_cnt_next   = r_cnt;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_bv_next    = 1'b0;
    w_fe_next    = 1'b0;
    unique case (r_rx_state)
      R_IDLE: begin
        w_cnt_next = '0;
        w_bit_next = '0;
        if (!r_rxd_s2) w_rx_next = R_START;
      end
      R_START: begin
        if (r_cnt == HALF_M1) begin
          w_cnt_next = '0;
          w_rx_next  = r_rxd_s2 ? R_IDLE : R_DATA;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      R_DATA: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_next   = '0;
          w_shift_next = {r_rxd_s2, r_shift[7:1]};
          if (r_bit == 3'd7) w_rx_next = R_STOP;
          else w_bit_next = r_bit + 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      R_STOP: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_next = '0;
          w_bv_next  = r_rxd_s2;
          w_fe_next  = !r_rxd_s2;
          w_rx_next  = R_IDLE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: w_rx_next = R_IDLE;
    endcase
  end

  ld_state_t r_ld_state;
  ld_state_t w_ld_next;
  logic [8:0] r_words_left;
  logic [8:0] w_words_left_next;
  logic [ADDR_W-1:0] r_word_idx;
  logic [ADDR_W-1:0] w_word_idx_next;
  logic [1:0] r_byte_idx;
  logic [1:0] w_byte_idx_next;
  logic [7:0] r_csum;
  logic [7:0] w_csum_next;
  logic [31:0] r_word;
  logic [31:0] w_word_next;
  logic r_we;
  logic w_we_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_next;
  logic [31:0] r_wdata;
  logic [31:0] w_wdata_next;
  logic r_done;
  logic w_done_next;
  logic r_error;
  logic w_error_next;
  logic r_hold;
  logic w_hold_next;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ld_state   <= L_IDLE;
      r_words_left <= '0;
      r_word_idx   <= '0;
      r_byte_idx   <= '0;
      r_csum       <= '0;
      r_word       <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_hold       <= 1'b1;
    end else begin
      r_ld_state   <= w_ld_next;
      r_words_left <= w_words_left_next;
      r_word_idx   <= w_word_idx_next;
      r_byte_idx   <= w_byte_idx_next;
      r_csum       <= w_csum_next;
      r_word       <= w_word_next;
      r_we         <= w_we_next;
      r_addr       <= w_addr_next;
      r_wdata      <= w_wdata_next;
      r_done       <= w_done_next;
      r_error      <= w_error_next;
      r_hold       <= w_hold_next;
    end
  end

  always_comb begin
    w_ld_next         = r_ld_state;
    w_words_left_next = r_words_left;
    w_word_idx_next   = r_word_idx;
    w_byte_idx_next   = r_byte_idx;
    w_csum_next       = r_csum;
    w_word_next       = r_word;
    w_we_next         = 1'b0;
    w_addr_next       = r_addr;
    w_wdata_next      = r_wdata;
    w_done_next       = r_done;
    w_error_next      = r_error;
    w_hold_next       = r_hold;
    unique case (r_ld_state)
      L_IDLE, L_DONE, L_ERR: begin
        if (r_byte_valid && r_shift == SYNC) begin
          w_ld_next    = L_COUNT;
          w_done_next  = 1'b0;
          w_error_next = 1'b0;
          w_hold_next  = 1'b1;
        end
      end
      L_COUNT: begin
        if (r_frame_err) begin
          w_ld_next    = L_ERR;
          w_error_next = 1'b1;
        end else if (r_byte_valid) begin
          // a count byte of zero encodes a full 256-word image
          w_words_left_next = (r_shift == 8'd0) ?
            9'd256 : {1'b0, r_shift};
          w_word_idx_next = '0;
          w_byte_idx_next = '0;
          w_csum_next     = '0;
          w_ld_next       = L_DATA;
        end
      end
      L_DATA: begin
        if (r_frame_err) begin
          w_ld_next    = L_ERR;
          w_error_next = 1'b1;
        end else if (r_byte_valid) begin
          w_csum_next = r_csum ^ r_shift;
          w_word_next[8*r_byte_idx +: 8] = r_shift;
          w_byte_idx_next = r_byte_idx + 1'b1;
          if (r_byte_idx == 2'd3) begin
            w_we_next    = 1'b1;
            w_addr_next  = r_word_idx;
            w_wdata_next = {r_shift, r_word[23:0]};
            w_word_idx_next   = r_word_idx + 1'b1;
            w_words_left_next = r_words_left - 1'b1;
            if (r_words_left == 9'd1) w_ld_next = L_CHECK;
          end
        end
      end
      L_CHECK: begin
        if (r_frame_err) begin
          w_ld_next    = L_ERR;
          w_error_next = 1'b1;
        end else if (r_byte_valid) begin
          if (r_shift == r_csum) begin
            w_ld_next   = L_DONE;
            w_done_next = 1'b1;
            w_hold_next = 1'b0;
          end else begin
            w_ld_next    = L_ERR;
            w_error_next = 1'b1;
          end
        end
      end
      default: w_ld_next = L_IDLE;
    endcase
  end

  assign o_mem.mem_we    = r_we;
  assign o_mem.mem_addr  = r_addr;
  assign o_mem.mem_wdata = r_wdata;
  assign o_mem.cpu_hold  = r_hold;
  assign o_mem.done      = r_done;
  assign o_mem.error     = r_error;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: serial
// frames in, expected memory writes and flags out.
module tb_uart_prog_loader;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic i_rxd = 1'b1;

  int total = 0;
  int bad = 0;

  logic [39:0] exp_q[$];
  logic [7:0]  tx_q[$];
  logic        prev_we = 1'b0;

  uart_prog_loader_if #(.ADDR_W(8)) bus ();

  uart_prog_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W(8)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .i_rxd(i_rxd),
    .o_mem(bus.master)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic [39:0] e;
    if (bus.mem_we) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write got=%h_%h want=none",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({bus.mem_addr, bus.mem_wdata} !== e) begin
          bad++;
          $display("FAIL write got=%h_%h want=%h_%h",
                   bus.mem_addr, bus.mem_wdata,
                   e[39:32], e[31:0]);
        end
      end
      total++;
      if (prev_we !== 1'b0) begin
        bad++;
        $display("FAIL strobe_width got=2+ want=1");
      end
    end
    prev_we = bus.mem_we;
  end

  task automatic send_byte(input logic [7:0] b,
                           input logic stop);
    @(posedge clk); #1;
    i_rxd = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      i_rxd = b[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    i_rxd = stop;
    repeat (CPB) @(posedge clk);
    #1;
    i_rxd = 1'b1;
    repeat (3*CPB) @(posedge clk);
  endtask

  task automatic send_q();
    while (tx_q.size() != 0) send_byte(tx_q.pop_front(), 1'b1);
  endtask

  task automatic settle();
    for (int i = 0; i < 200; i++) begin
      if (bus.done || bus.error) break;
      @(posedge clk);
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_flags(input string tag,
                             input logic d,
                             input logic e,
                             input logic h);
    total++;
    if ({bus.done, bus.error, bus.cpu_hold} !== {d, e, h}) begin
      bad++;
      $display("FAIL %s flags(done,err,hold) got=%b%b%b want=%b%b%b",
               tag, bus.done, bus.error, bus.cpu_hold, d, e, h);
    end
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL %s pending_writes got=%0d want=0",
               tag, exp_q.size());
    end
  endtask

  task automatic push_frame2();
    exp_q.push_back({8'h00, 32'h0000_0033});
    exp_q.push_back({8'h01, 32'h0010_0093});
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    i_rxd  = 1'b1;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (200) @(posedge clk);
    @(negedge clk);
    check_flags("reset", 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_single_word();
    exp_q.push_back({8'h00, 32'h0000_0013});
    tx_q = {8'hA5, 8'h01, 8'h13, 8'h00,
            8'h00, 8'h00, 8'h13};
    send_q();
    settle();
    check_flags("single", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_two_words();
    push_frame2();
    tx_q = {8'hA5, 8'h02, 8'h33, 8'h00, 8'h00, 8'h00,
            8'h93, 8'h00, 8'h10, 8'h00, 8'hB0};
    send_q();
    settle();
    check_flags("two_words", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_bad_checksum();
    exp_q.push_back({8'h00, 32'h0000_0013});
    tx_q = {8'hA5, 8'h01, 8'h13, 8'h00,
            8'h00, 8'h00, 8'hFF};
    send_q();
    settle();
    check_flags("bad_csum", 1'b0, 1'b1, 1'b1);
    push_frame2();
    tx_q = {8'hA5, 8'h02, 8'h33, 8'h00, 8'h00, 8'h00,
            8'h93, 8'h00, 8'h10, 8'h00, 8'hB0};
    send_q();
    settle();
    check_flags("recover", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_noise_and_framing();
    tx_q = {8'h00, 8'hFF, 8'h5A};
    send_q();
    @(negedge clk);
    check_flags("noise", 1'b1, 1'b0, 1'b0);
    tx_q = {8'hA5, 8'h02};
    send_q();
    @(negedge clk);
    check_flags("mid_load", 1'b0, 1'b0, 1'b1);
    push_frame2();
    tx_q = {8'h33, 8'h00, 8'h00, 8'h00,
            8'h93, 8'h00, 8'h10, 8'h00, 8'hB0};
    send_q();
    settle();
    check_flags("after_noise", 1'b1, 1'b0, 1'b0);
    tx_q = {8'hA5, 8'h01, 8'h13, 8'h00};
    send_q();
    send_byte(8'h00, 1'b0);
    settle();
    check_flags("framing", 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_reset_abort();
    tx_q = {8'hA5, 8'h02, 8'h33, 8'h00};
    send_q();
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    tx_q = {8'h00, 8'h00, 8'h93, 8'h00,
            8'h10, 8'h00, 8'hB0};
    send_q();
    settle();
    check_flags("reset_abort", 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_two_words();
    test_bad_checksum();
    test_noise_and_framing();
    test_reset_abort();
    repeat (10) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
